dmem_arbiter: RTL

- Two-requester arbiter and sequencer that shares the single-ported data memory.
- Port 0 is the pipeline load/store unit; port 1 is the debug/DMA loader.
- Accepts one word-aligned transaction at a time, drives the memory strobes for a fixed latency, then returns read data or a write acknowledge to the winning port.
- Sits between the LSU/debug logic and the data memory block.

---
 rtl/dmem_arbiter_pkg.sv | 16 +
 rtl/dmem_arbiter_rr_pick2.sv | 25 ++
 rtl/dmem_arbiter.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types and constants for the data-memory arbiter.
// The state encoding, port indices and counter width live here.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  localparam logic       PORT_LSU = 1'b0;
  localparam logic       PORT_DBG = 1'b1;
  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam int         CNT_W    = 4;

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way picker: round-robin on last grant, or fixed priority to port 0.
module rr_pick2
  import dmem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr_en,
  output logic [1:0] gnt,
  output logic       idx
);

  always_comb begin
    idx = PORT_LSU;
    gnt = 2'b00;
    if (req == 2'b11) begin
      idx = rr_en ? ~last : PORT_LSU;
    end else if (req[1]) begin
      idx = PORT_DBG;
    end
    if (req != 2'b00) begin
      gnt = idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for the single-ported data memory (LSU on port 0, debug/DMA on port 1).
// State | meaning: IDLE = pick winner, grant, latch | ACCESS = strobes held LAT cycles | RESP = one-cycle rvalid to winner
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int LAT = 1,
  parameter bit RR  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_be,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_be,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  output logic        mem_read,
  output logic        mem_write,
  input  logic [31:0] mem_rdata
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              win_idx;
  logic              last_gnt;
  logic              l_we;
  logic [31:0]       l_addr;
  logic [31:0]       l_wdata;
  logic [3:0]        l_be;
  logic [31:0]       resp_data;
  logic              resp_err;

  logic [1:0]        pick_gnt;
  logic              pick_idx;
  logic              sel_we;
  logic [31:0]       sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_be;
  logic              sel_ok;
  logic              in_access;
  logic              in_resp;

  rr_pick2 u_pick (
    .req   ({p1_req, p0_req}),
    .last  (last_gnt),
    .rr_en (RR),
    .gnt   (pick_gnt),
    .idx   (pick_idx)
  );

  always_comb begin
    sel_we    = pick_idx ? p1_we    : p0_we;
    sel_addr  = pick_idx ? p1_addr  : p0_addr;
    sel_wdata = pick_idx ? p1_wdata : p0_wdata;
    sel_be    = pick_idx ? p1_be    : p0_be;
    sel_ok    = (sel_addr[1:0] == 2'b00) && (sel_be != 4'b0000);
  end

  // Grant is gated by rst so every output reads 0 while reset is held.
  assign p0_gnt = !rst && (state == S_IDLE) && pick_gnt[0];
  assign p1_gnt = !rst && (state == S_IDLE) && pick_gnt[1];

  assign in_access = (state == S_ACCESS);
  assign in_resp   = (state == S_RESP);

  assign mem_read  = in_access && !l_we;
  assign mem_write = in_access && l_we;
  assign mem_addr  = in_access ? l_addr  : 32'd0;
  assign mem_wdata = in_access ? l_wdata : 32'd0;
  assign mem_be    = in_access ? l_be    : 4'd0;

  assign p0_rvalid = in_resp && (win_idx == PORT_LSU);
  assign p1_rvalid = in_resp && (win_idx == PORT_DBG);
  assign p0_rdata  = p0_rvalid ? resp_data : 32'd0;
  assign p1_rdata  = p1_rvalid ? resp_data : 32'd0;
  assign p0_err    = p0_rvalid && resp_err;
  assign p1_err    = p1_rvalid && resp_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      win_idx   <= PORT_LSU;
      last_gnt  <= PORT_DBG;
      l_we      <= 1'b0;
      l_addr    <= '0;
      l_wdata   <= '0;
      l_be      <= '0;
      resp_data <= '0;
      resp_err  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (p0_req || p1_req) begin
            win_idx <= pick_idx;
            l_we    <= sel_we;
            l_addr  <= sel_addr;
            l_wdata <= sel_wdata;
            l_be    <= sel_be;
            if (sel_ok) begin
              state    <= S_ACCESS;
              cnt      <= CNT_LOAD;
              resp_err <= 1'b0;
            end else begin
              state     <= S_RESP;
              resp_err  <= 1'b1;
              resp_data <= '0;
            end
          end
        end
        S_ACCESS: begin
          if (cnt == '0) begin
            resp_data <= l_we ? 32'd0 : mem_rdata;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        S_RESP: begin
          last_gnt  <= win_idx;
          resp_data <= '0;
          resp_err  <= 1'b0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
